// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed driver for an N-digit common-anode 7-segment
// display. Shadows a hex word plus decimal points on a load strobe, scans the
// digits with a dark guard interval at the start of every slot, and decodes
// to active-low segments with optional leading-zero suppression.
module seg7_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lzs,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sgm
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          sgm_q, sgm_d;

  logic [DIGITS-1:0]   lead_zero;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                suppress;

  // Hex nibble to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Prescaler and digit index: idx advances when cnt wraps.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow registers follow data/dp_in only on load.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (load) begin
      shadow_data_d = data;
      shadow_dp_d   = dp_in;
    end
  end

  // lead_zero[i] is set when nibbles i..DIGITS-1 are all zero.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (shadow_data_q[4*i +: 4] == 4'h0);
      lead_zero[i] = all_zero;
    end
  end

  // Next output values: dark during guard, otherwise the current digit.
  always_comb begin
    cur_nib  = shadow_data_q[{idx_q, 2'b00} +: 4];
    cur_dp   = shadow_dp_q[idx_q];
    suppress = lzs && (idx_q != '0) && lead_zero[idx_q];
    an_d     = '1;
    sgm_d    = 8'hFF;
    if (cnt_q >= CNT_W'(GUARD)) begin
      an_d[idx_q] = 1'b0;
      sgm_d       = {(suppress ? 7'h7F : hex_decode(cur_nib)), ~cur_dp};
    end
  end

  // State and output registers; reset blanks the display at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      an_q          <= '1;
      sgm_q         <= 8'hFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      an_q          <= an_d;
      sgm_q         <= sgm_d;
    end
  end

  assign an  = an_q;
  assign sgm = sgm_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with DIGITS=4, SCAN_DIV=8, GUARD=2.
module tb_seg7_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        load;
  logic        lzs;
  logic [3:0]  an;
  logic [7:0]  sgm;

  always #5 clk = ~clk;

  seg7_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .dp_in (dp_in),
    .load  (load),
    .lzs   (lzs),
    .an    (an),
    .sgm   (sgm)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Slot position is derived from the number of edges since reset:
  // edge n (0-based) sees phase n % SCAN_DIV of digit (n / SCAN_DIV) % DIGITS.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int          edge_n  = 0;
  logic [15:0] m_data  = '0;
  logic [3:0]  m_dp    = '0;
  logic [3:0]  exp_an  = 4'hF;
  logic [7:0]  exp_sgm = 8'hFF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n  = 0;
      m_data  = '0;
      m_dp    = '0;
      exp_an  = 4'hF;
      exp_sgm = 8'hFF;
    end else begin
      int ph, dig;
      logic [15:0] upper;
      logic [6:0]  seg;
      ph    = edge_n % SCAN_DIV;
      dig   = (edge_n / SCAN_DIV) % DIGITS;
      upper = m_data >> (4 * dig);
      if (ph < GUARD) begin
        exp_an  = 4'hF;
        exp_sgm = 8'hFF;
      end else begin
        exp_an = 4'hF & ~(4'b1 << dig);
        seg    = seg_tab[upper[3:0]];
        if (lzs && dig > 0 && upper == 16'h0) seg = 7'h7F;
        exp_sgm = {seg, ~m_dp[dig]};
      end
      if (load) begin
        m_data = data;
        m_dp   = dp_in;
      end
      edge_n++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [3:0] prev_an = 4'hF;

  // Advance to the next falling edge and compare against the model.
  task automatic tick();
    @(negedge clk);
    chk("model_an", {28'h0, an}, {28'h0, exp_an});
    chk("model_sgm", {24'h0, sgm}, {24'h0, exp_sgm});
    chk("one_anode", {31'h0, ($countones(~an) <= 1)}, 32'h1);
    if ($countones(~an) == 1 && $countones(~prev_an) == 1)
      chk("guard_gap", {31'h0, (an != prev_an)}, 32'h0);
    prev_an = an;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data  = d;
    dp_in = dp;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Wait (bounded) until digit d is lit.
  task automatic wait_lit(input int d);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (an == (4'hF & ~(4'b1 << d))) found = 1'b1;
    end
    chk("wait_lit_timeout", {31'h0, found}, 32'h1);
  endtask

  // Edge-accurate startup sequence after reset release (shadow = 0, lzs = 0).
  task automatic check_startup(input string tag);
    for (int e = 1; e <= 35; e++) begin
      tick();
      case (e)
        1, 2, 9, 10, 33, 34: chk({tag, "_dark"}, {28'h0, an}, 32'hF);
        3, 8, 35:            chk({tag, "_dig0"}, {28'h0, an}, 32'hE);
        11:                  chk({tag, "_dig1"}, {28'h0, an}, 32'hD);
        default: ;
      endcase
      if (e == 1) chk({tag, "_sgm_dark"}, {24'h0, sgm}, 32'hFF);
      if (e == 3) chk({tag, "_sgm_zero"}, {24'h0, sgm}, 32'h03);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lzs;
    int          digit;
    logic [7:0]  sgm;
  } vec_t;

  vec_t vecs [16];

  // Per-digit expectation for 16'h12AF with no dp lit.
  logic [7:0] exp_q [$];

  initial begin
    vecs[0]  = '{16'h12AF, 4'b0100, 1'b0, 0, 8'h71};
    vecs[1]  = '{16'h12AF, 4'b0100, 1'b0, 1, 8'h11};
    vecs[2]  = '{16'h12AF, 4'b0100, 1'b0, 2, 8'h24};
    vecs[3]  = '{16'h12AF, 4'b0100, 1'b0, 3, 8'h9F};
    vecs[4]  = '{16'h0050, 4'b0000, 1'b1, 3, 8'hFF};
    vecs[5]  = '{16'h0050, 4'b0000, 1'b1, 2, 8'hFF};
    vecs[6]  = '{16'h0050, 4'b0000, 1'b1, 1, 8'h49};
    vecs[7]  = '{16'h0050, 4'b0000, 1'b1, 0, 8'h03};
    vecs[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 8'h03};
    vecs[9]  = '{16'h0000, 4'b0000, 1'b1, 1, 8'hFF};
    vecs[10] = '{16'h0000, 4'b0000, 1'b1, 2, 8'hFF};
    vecs[11] = '{16'h0000, 4'b0000, 1'b1, 3, 8'hFF};
    vecs[12] = '{16'h0000, 4'b0000, 1'b0, 0, 8'h03};
    vecs[13] = '{16'h0000, 4'b0000, 1'b0, 1, 8'h03};
    vecs[14] = '{16'h0000, 4'b0000, 1'b0, 2, 8'h03};
    vecs[15] = '{16'h0000, 4'b0000, 1'b0, 3, 8'h03};

    rst_n = 1'b0;
    data  = '0;
    dp_in = '0;
    load  = 1'b0;
    lzs   = 1'b0;

    // Reset held: display dark.
    tick();
    tick();
    chk("reset_an", {28'h0, an}, 32'hF);
    chk("reset_sgm", {24'h0, sgm}, 32'hFF);
    rst_n = 1'b1;
    check_startup("startup");

    // Decode, dp and suppression vectors.
    for (int v = 0; v < 16; v++) begin
      lzs = vecs[v].lzs;
      do_load(vecs[v].data, vecs[v].dp);
      wait_lit(vecs[v].digit);
      chk($sformatf("vec%0d_sgm", v), {24'h0, sgm}, {24'h0, vecs[v].sgm});
    end

    // Shadowing: data changes without load must not reach the display.
    lzs = 1'b0;
    do_load(16'h12AF, 4'b0000);
    data = 16'hFFFF;
    exp_q = '{8'h71, 8'h11, 8'h25, 8'h9F};
    for (int c = 0; c < 32; c++) begin
      tick();
      for (int d = 0; d < DIGITS; d++)
        if (an == (4'hF & ~(4'b1 << d)))
          chk($sformatf("shadow_hold_d%0d", d), {24'h0, sgm}, {24'h0, exp_q[d]});
    end

    // Mid-slot load: new value appears one cycle after the loading edge.
    wait_lit(0);
    data = 16'h1238;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("midload_old", {24'h0, sgm}, 32'h71);
    tick();
    chk("midload_an", {28'h0, an}, 32'hE);
    chk("midload_new", {24'h0, sgm}, 32'h01);

    // Randomised traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      data  = 16'($urandom) & mask;
      dp_in = 4'($urandom_range(0, 15));
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) lzs = ~lzs;
      tick();
    end
    load = 1'b0;
    lzs  = 1'b0;

    // Asynchronous reset while digit 2 is lit.
    do_load(16'h9876, 4'b1111);
    wait_lit(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {28'h0, an}, 32'hF);
    chk("async_sgm", {24'h0, sgm}, 32'hFF);
    tick();
    rst_n = 1'b1;
    check_startup("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
